// File: rtl/ysyx_25040105_mem_arb.sv
// ysyx_25040105_mem_arb
// Shares the single pmem data port between the IFU (read-only fetch) and
// the LSU (load/store). Transactions are strictly serialised. An IDLE ->
// REQ -> WAIT -> RESP sequence runs per transaction, so at most one
// transaction is in flight.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width (multiple of 8)
//   RR_EN   1 = alternate on a tie, 0 = LSU always wins a tie
//
// Ports:
//   clk, rst                  rising-edge clock, async active-low reset
//   ifu_req_valid/ready       IFU request handshake (ready only in IDLE)
//   ifu_addr                  fetch address
//   ifu_rsp_valid, ifu_rdata  one-cycle fetch response, held data
//   lsu_req_valid/ready       LSU request handshake (ready only in IDLE)
//   lsu_addr, lsu_wen,
//   lsu_wdata, lsu_wmask      LSU request fields
//   lsu_rsp_valid, lsu_rdata  one-cycle LSU response (rdata 0 for stores)
//   mem_req_valid/ready       request handshake toward the memory wrapper
//   mem_addr, mem_wen,
//   mem_wdata, mem_wmask      latched request fields, stable while in flight
//   mem_rsp_valid, mem_rdata  memory response
//   busy                      arbiter is not idle

module ysyx_25040105_mem_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic {
        SRC_IFU = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

    state_t state;
    src_t   last_grant;
    src_t   owner;

    logic   grant_ifu;
    logic   grant_lsu;

    // Grant is combinational so the winner sees ready in the same cycle.
    // It is held off during reset so no handshake completes while rst is low.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (rst && state == S_IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (RR_EN && last_grant == SRC_LSU) begin
                    grant_ifu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            last_grant    <= SRC_IFU;
            owner         <= SRC_IFU;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rdata     <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rdata     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_lsu) begin
                        owner         <= SRC_LSU;
                        last_grant    <= SRC_LSU;
                        mem_addr      <= lsu_addr;
                        mem_wen       <= lsu_wen;
                        mem_wdata     <= lsu_wdata;
                        mem_wmask     <= lsu_wmask;
                        mem_req_valid <= 1'b1;
                        state         <= S_REQ;
                    end else if (grant_ifu) begin
                        // Fetches are always plain reads with no write data.
                        owner         <= SRC_IFU;
                        last_grant    <= SRC_IFU;
                        mem_addr      <= ifu_addr;
                        mem_wen       <= 1'b0;
                        mem_wdata     <= '0;
                        mem_wmask     <= '0;
                        mem_req_valid <= 1'b1;
                        state         <= S_REQ;
                    end
                end

                S_REQ: begin
                    // Any mem_rsp_valid here is stray and deliberately ignored.
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (owner == SRC_LSU) begin
                            // A store completes with zero data, not bus residue.
                            lsu_rdata     <= mem_wen ? '0 : mem_rdata;
                            lsu_rsp_valid <= 1'b1;
                        end else begin
                            ifu_rdata     <= mem_rdata;
                            ifu_rsp_valid <= 1'b1;
                        end
                        state <= S_RESP;
                    end
                end

                S_RESP: begin
                    ifu_rsp_valid <= 1'b0;
                    lsu_rsp_valid <= 1'b0;
                    state         <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040105_mem_arb.sv
// Bench for ysyx_25040105_mem_arb. Lane 0 runs an RR_EN=1 instance and lane 1
// runs an RR_EN=0 instance. Each lane has its own requesters and memory.
// A transaction-level model per lane predicts every output on every cycle.
// Directed sequences add literal expectations on top of that model.

module tb_ysyx_25040105_mem_arb;

    logic        clk = 1'b0;
    logic        rst;

    logic        ifu_req_valid [2];
    logic        ifu_req_ready [2];
    logic [31:0] ifu_addr      [2];
    logic        ifu_rsp_valid [2];
    logic [31:0] ifu_rdata     [2];
    logic        lsu_req_valid [2];
    logic        lsu_req_ready [2];
    logic [31:0] lsu_addr      [2];
    logic        lsu_wen       [2];
    logic [31:0] lsu_wdata     [2];
    logic [3:0]  lsu_wmask     [2];
    logic        lsu_rsp_valid [2];
    logic [31:0] lsu_rdata     [2];
    logic        mem_req_valid [2];
    logic        mem_req_ready [2];
    logic [31:0] mem_addr      [2];
    logic        mem_wen       [2];
    logic [31:0] mem_wdata     [2];
    logic [3:0]  mem_wmask     [2];
    logic        mem_rsp_valid [2];
    logic [31:0] mem_rdata     [2];
    logic        busy          [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        ysyx_25040105_mem_arb #(
            .ADDR_W(32),
            .DATA_W(32),
            .RR_EN (g == 0)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .ifu_req_valid(ifu_req_valid[g]),
            .ifu_req_ready(ifu_req_ready[g]),
            .ifu_addr     (ifu_addr[g]),
            .ifu_rsp_valid(ifu_rsp_valid[g]),
            .ifu_rdata    (ifu_rdata[g]),
            .lsu_req_valid(lsu_req_valid[g]),
            .lsu_req_ready(lsu_req_ready[g]),
            .lsu_addr     (lsu_addr[g]),
            .lsu_wen      (lsu_wen[g]),
            .lsu_wdata    (lsu_wdata[g]),
            .lsu_wmask    (lsu_wmask[g]),
            .lsu_rsp_valid(lsu_rsp_valid[g]),
            .lsu_rdata    (lsu_rdata[g]),
            .mem_req_valid(mem_req_valid[g]),
            .mem_req_ready(mem_req_ready[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wen      (mem_wen[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_wmask    (mem_wmask[g]),
            .mem_rsp_valid(mem_rsp_valid[g]),
            .mem_rdata    (mem_rdata[g]),
            .busy         (busy[g])
        );
    end

    task automatic check(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h", nm, l, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Per lane: is a transaction outstanding, has memory taken the request,
    // is this the response-delivery cycle, who owns it, and who won last.
    bit          m_busy   [2];
    bit          m_issued [2];
    bit          m_resp   [2];
    bit          m_lsu    [2];   // owner: 1 = LSU
    bit          m_last   [2];   // last grant: 1 = LSU
    logic [31:0] m_addr   [2];
    bit          m_wen    [2];
    logic [31:0] m_wdata  [2];
    logic [3:0]  m_wmask  [2];
    logic [31:0] m_ird    [2];
    logic [31:0] m_lrd    [2];
    bit          gi       [2];
    bit          gl       [2];

    always @(negedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (!rst) begin
                m_busy[l] = 0; m_issued[l] = 0; m_resp[l] = 0;
                m_lsu[l] = 0; m_last[l] = 0;
                m_addr[l] = '0; m_wen[l] = 0; m_wdata[l] = '0; m_wmask[l] = '0;
                m_ird[l] = '0; m_lrd[l] = '0;
                check("rst_ifu_req_ready", l, 32'(ifu_req_ready[l]), 0);
                check("rst_lsu_req_ready", l, 32'(lsu_req_ready[l]), 0);
                check("rst_mem_req_valid", l, 32'(mem_req_valid[l]), 0);
                check("rst_ifu_rsp_valid", l, 32'(ifu_rsp_valid[l]), 0);
                check("rst_lsu_rsp_valid", l, 32'(lsu_rsp_valid[l]), 0);
                check("rst_busy",          l, 32'(busy[l]), 0);
                check("rst_mem_addr",      l, mem_addr[l], 0);
                check("rst_mem_wen",       l, 32'(mem_wen[l]), 0);
                check("rst_mem_wdata",     l, mem_wdata[l], 0);
                check("rst_mem_wmask",     l, 32'(mem_wmask[l]), 0);
                check("rst_ifu_rdata",     l, ifu_rdata[l], 0);
                check("rst_lsu_rdata",     l, lsu_rdata[l], 0);
            end else begin
                // A tie goes to the LSU unless alternation is on and the LSU won last.
                gi[l] = !m_busy[l] && ifu_req_valid[l] &&
                        (!lsu_req_valid[l] || (l == 0 && m_last[l]));
                gl[l] = !m_busy[l] && lsu_req_valid[l] && !gi[l];

                check("ifu_req_ready", l, 32'(ifu_req_ready[l]), 32'(gi[l]));
                check("lsu_req_ready", l, 32'(lsu_req_ready[l]), 32'(gl[l]));
                check("busy",          l, 32'(busy[l]), 32'(m_busy[l]));
                check("mem_req_valid", l, 32'(mem_req_valid[l]), 32'(m_busy[l] && !m_issued[l]));
                check("ifu_rsp_valid", l, 32'(ifu_rsp_valid[l]), 32'(m_resp[l] && !m_lsu[l]));
                check("lsu_rsp_valid", l, 32'(lsu_rsp_valid[l]), 32'(m_resp[l] && m_lsu[l]));
                check("mem_addr",      l, mem_addr[l], m_addr[l]);
                check("mem_wen",       l, 32'(mem_wen[l]), 32'(m_wen[l]));
                check("mem_wdata",     l, mem_wdata[l], m_wdata[l]);
                check("mem_wmask",     l, 32'(mem_wmask[l]), 32'(m_wmask[l]));
                check("ifu_rdata",     l, ifu_rdata[l], m_ird[l]);
                check("lsu_rdata",     l, lsu_rdata[l], m_lrd[l]);

                if (m_resp[l]) begin
                    m_resp[l] = 0;
                    m_busy[l] = 0;
                end else if (!m_busy[l]) begin
                    if (gi[l]) begin
                        m_busy[l] = 1; m_issued[l] = 0; m_lsu[l] = 0; m_last[l] = 0;
                        m_addr[l] = ifu_addr[l]; m_wen[l] = 0; m_wdata[l] = '0; m_wmask[l] = '0;
                    end else if (gl[l]) begin
                        m_busy[l] = 1; m_issued[l] = 0; m_lsu[l] = 1; m_last[l] = 1;
                        m_addr[l] = lsu_addr[l]; m_wen[l] = lsu_wen[l];
                        m_wdata[l] = lsu_wdata[l]; m_wmask[l] = lsu_wmask[l];
                    end
                end else if (!m_issued[l]) begin
                    if (mem_req_ready[l]) m_issued[l] = 1;
                end else if (mem_rsp_valid[l]) begin
                    m_resp[l] = 1;
                    if (m_lsu[l]) m_lrd[l] = m_wen[l] ? 32'h0 : mem_rdata[l];
                    else          m_ird[l] = mem_rdata[l];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        for (int l = 0; l < 2; l++) begin
            ifu_req_valid[l] = 0; ifu_addr[l] = '0;
            lsu_req_valid[l] = 0; lsu_addr[l] = '0; lsu_wen[l] = 0;
            lsu_wdata[l] = '0; lsu_wmask[l] = '0;
            mem_req_ready[l] = 0; mem_rsp_valid[l] = 0; mem_rdata[l] = '0;
        end
    endtask

    bit       ifire [2];
    bit       lfire [2];
    int       ngr   [2];
    bit [3:0] order [2];
    int       pulses;

    initial begin
        rst = 1'b0;
        quiet_inputs();
        tick(); tick();
        rst = 1'b1;

        // Single fetch: memory ready at once, data one cycle into WAIT.
        tick();
        ifu_req_valid[0] = 1; ifu_addr[0] = 32'h8000_0000; mem_req_ready[0] = 1;
        @(negedge clk);
        check("fetch_accept", 0, 32'(ifu_req_ready[0]), 1);
        tick();
        ifu_req_valid[0] = 0; ifu_addr[0] = '0;
        @(negedge clk);
        check("fetch_mem_valid", 0, 32'(mem_req_valid[0]), 1);
        check("fetch_mem_addr",  0, mem_addr[0], 32'h8000_0000);
        tick();
        mem_rsp_valid[0] = 1; mem_rdata[0] = 32'h0010_0073;
        @(negedge clk);
        check("fetch_wait_busy", 0, 32'(busy[0]), 1);
        tick();
        mem_rsp_valid[0] = 0; mem_rdata[0] = '0; mem_req_ready[0] = 0;
        @(negedge clk);
        check("fetch_rsp_valid", 0, 32'(ifu_rsp_valid[0]), 1);
        check("fetch_rdata",     0, ifu_rdata[0], 32'h0010_0073);
        check("fetch_lsu_quiet", 0, 32'(lsu_rsp_valid[0]), 0);
        tick();
        @(negedge clk);
        check("fetch_rsp_once", 0, 32'(ifu_rsp_valid[0]), 0);
        check("fetch_idle",     0, 32'(busy[0]), 0);

        // LSU store held off by memory for three cycles.
        tick();
        lsu_req_valid[0] = 1; lsu_addr[0] = 32'h8000_1000; lsu_wen[0] = 1;
        lsu_wdata[0] = 32'hDEAD_BEEF; lsu_wmask[0] = 4'b0011;
        @(negedge clk);
        check("store_accept", 0, 32'(lsu_req_ready[0]), 1);
        tick();
        lsu_req_valid[0] = 0; lsu_addr[0] = '0; lsu_wen[0] = 0;
        lsu_wdata[0] = '0; lsu_wmask[0] = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("store_hold_valid", 0, 32'(mem_req_valid[0]), 1);
            check("store_hold_wen",   0, 32'(mem_wen[0]), 1);
            check("store_hold_addr",  0, mem_addr[0], 32'h8000_1000);
            check("store_hold_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
            check("store_hold_wmask", 0, 32'(mem_wmask[0]), 32'h3);
            tick();
        end
        mem_req_ready[0] = 1;
        @(negedge clk);
        tick();
        mem_req_ready[0] = 0; mem_rsp_valid[0] = 1; mem_rdata[0] = 32'h1234_5678;
        @(negedge clk);
        tick();
        mem_rsp_valid[0] = 0;
        @(negedge clk);
        check("store_rsp_valid",  0, 32'(lsu_rsp_valid[0]), 1);
        check("store_rdata_zero", 0, lsu_rdata[0], 32'h0);
        check("store_ifu_quiet",  0, 32'(ifu_rsp_valid[0]), 0);
        check("store_ifu_held",   0, ifu_rdata[0], 32'h0010_0073);

        // Slow memory with a stray response during REQ; response 5 cycles after accept.
        tick();
        ifu_req_valid[0] = 1; ifu_addr[0] = 32'h8000_0040;
        @(negedge clk);
        check("slow_accept", 0, 32'(ifu_req_ready[0]), 1);
        pulses = 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            ifu_req_valid[0] = 0;
            mem_rsp_valid[0] = (t == 1) || (t == 5);
            mem_rdata[0]     = (t == 1) ? 32'hBAD0_BAD0 : 32'hCAFE_F00D;
            mem_req_ready[0] = (t == 2);
            @(negedge clk);
            if (ifu_rsp_valid[0]) pulses++;
            check("slow_busy", 0, 32'(busy[0]), (t <= 6) ? 32'h1 : 32'h0);
            if (t == 6) check("slow_rdata", 0, ifu_rdata[0], 32'hCAFE_F00D);
        end
        check("slow_one_rsp", 0, pulses, 1);
        mem_rsp_valid[0] = 0;

        // Reset while in WAIT, then a late memory response must be dropped.
        tick();
        ifu_req_valid[0] = 1; ifu_addr[0] = 32'h8000_0080; mem_req_ready[0] = 1;
        @(negedge clk);
        tick();
        ifu_req_valid[0] = 0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rw_in_wait", 0, 32'(busy[0]), 1);
        #1 rst = 1'b0;
        #1;
        check("rw_async_busy",  0, 32'(busy[0]), 0);
        check("rw_async_rdata", 0, ifu_rdata[0], 0);
        @(negedge clk);
        tick();
        rst = 1'b1; mem_req_ready[0] = 0; mem_rsp_valid[0] = 1; mem_rdata[0] = 32'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rw_no_rsp",   0, 32'(ifu_rsp_valid[0] | lsu_rsp_valid[0]), 0);
            check("rw_idle",     0, 32'(busy[0]), 0);
            check("rw_no_memrq", 0, 32'(mem_req_valid[0]), 0);
            tick();
        end
        mem_rsp_valid[0] = 0;

        // Both requesters held valid after reset: grant order per lane.
        for (int l = 0; l < 2; l++) begin
            ifu_req_valid[l] = 1; ifu_addr[l] = 32'h8000_0100;
            lsu_req_valid[l] = 1; lsu_addr[l] = 32'h8000_2000; lsu_wen[l] = 0;
            mem_req_ready[l] = 1; mem_rsp_valid[l] = 1; mem_rdata[l] = 32'h0BAD_F00D + l;
            ngr[l] = 0; order[l] = '0;
        end
        for (int c = 0; c < 40 && (ngr[0] < 4 || ngr[1] < 4); c++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                if (ngr[l] < 4 && (ifu_req_ready[l] || lsu_req_ready[l])) begin
                    order[l] = {order[l][2:0], lsu_req_ready[l]};
                    ngr[l]++;
                end
            end
            tick();
        end
        check("order_count_rr", 0, ngr[0], 4);
        check("order_count_fp", 1, ngr[1], 4);
        check("order_rr", 0, 32'(order[0]), 32'b1010);
        check("order_fp", 1, 32'(order[1]), 32'b1111);
        for (int l = 0; l < 2; l++) begin
            ifu_req_valid[l] = 0; lsu_req_valid[l] = 0;
        end
        repeat (5) tick();
        @(negedge clk);
        check("order_drain", 0, 32'(busy[0]), 0);
        check("order_drain", 1, 32'(busy[1]), 0);

        // IFU valid low where a grant would otherwise happen: nothing starts.
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            ifu_req_valid[0] = (i == 1) ? 1'b0 : 1'b0;
            ifu_addr[0] = 32'h8000_0200;
            @(negedge clk);
            check("drop_no_ready", 0, 32'(ifu_req_ready[0]), 0);
            check("drop_idle",     0, 32'(busy[0]), 0);
        end
        tick();
        ifu_req_valid[0] = 1;
        @(negedge clk);
        check("drop_then_grant", 0, 32'(ifu_req_ready[0]), 1);
        tick();
        ifu_req_valid[0] = 0; mem_req_ready[0] = 1; mem_rsp_valid[0] = 1;
        repeat (4) tick();
        quiet_inputs();

        // Randomized traffic on both lanes; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                ifire[l] = ifu_req_valid[l] && ifu_req_ready[l];
                lfire[l] = lsu_req_valid[l] && lsu_req_ready[l];
            end
            tick();
            for (int l = 0; l < 2; l++) begin
                if (ifu_req_valid[l] && !ifire[l]) begin
                    if ($urandom_range(15) == 0) ifu_req_valid[l] = 0;
                end else begin
                    ifu_req_valid[l] = ($urandom_range(2) == 0);
                    ifu_addr[l]      = $urandom & 32'hFFFF_FFFC;
                end
                if (lsu_req_valid[l] && !lfire[l]) begin
                    if ($urandom_range(15) == 0) lsu_req_valid[l] = 0;
                end else begin
                    lsu_req_valid[l] = ($urandom_range(2) == 0);
                    lsu_addr[l]      = $urandom;
                    lsu_wen[l]       = $urandom_range(1) == 1;
                    lsu_wdata[l]     = $urandom;
                    lsu_wmask[l]     = 4'($urandom_range(15));
                end
                mem_req_ready[l] = ($urandom_range(2) != 0);
                mem_rsp_valid[l] = ($urandom_range(2) == 0);
                mem_rdata[l]     = $urandom;
            end
        end

        quiet_inputs();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040105_mem_arb.md
Name: ysyx_25040105_mem_arb

Overview:
- Two-requester arbiter/sequencer that shares the single pmem data port between the IFU (instruction fetch, read-only) and the LSU (load/store).
- Sits between both units and the memory-access wrapper that calls pmem_read and pmem_write.
- Serialises transactions through a four-state FSM. Only one transaction is in flight at a time.
- Grants by round-robin, or by fixed LSU priority, selected by parameter.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RR_EN, 1, 1 = round-robin on tie, 0 = LSU always wins a tie.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse.
- ifu_rdata  out  DATA_W  fetched word.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  byte mask.
- lsu_rsp_valid  out  1  load data / store-done, one-cycle pulse.
- lsu_rdata  out  DATA_W  load data (0 for stores).
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  latched address.
- mem_wen  out  1  latched write enable.
- mem_wdata  out  DATA_W  latched write data.
- mem_wmask  out  DATA_W/8  latched mask.
- mem_rsp_valid  in  1  memory response.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=IFU, owner=IFU.
  - All *_valid, *_ready and busy outputs = 0.
  - mem_addr, mem_wdata, mem_wmask, mem_wen, ifu_rdata, lsu_rdata = 0.
  - Any in-flight transaction is dropped; no response is issued after reset.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Grant is combinational from the request valids.
  - Only one valid: that requester is granted.
  - Both valid, RR_EN=1: grant the requester that is not last_grant.
  - Both valid, RR_EN=0: grant the LSU.
  - The granted requester's *_req_ready=1 in the same cycle; the other's ready=0.
  - On grant: latch addr, wen, wdata, wmask (IFU: wen=0, wdata=0, wmask=0), set owner and last_grant, go to REQ.
  - No request: stay in IDLE, all readies 0.
- REQ:
  - mem_req_valid=1 and stays asserted until mem_req_ready.
  - The mem_* fields hold stable.
  - On mem_req_ready: go to WAIT; mem_req_valid drops next cycle.
- WAIT:
  - Wait for mem_rsp_valid, with no timeout.
  - On mem_rsp_valid: latch mem_rdata into the owner's rdata register (LSU store latches 0), go to RESP.
  - A mem_rsp_valid seen in IDLE or REQ is ignored.
- RESP:
  - The owner's *_rsp_valid=1 for exactly one cycle, then go to IDLE.
  - The non-owner's rsp_valid stays 0.
  - Both rdata registers hold their value until the next response to the same requester.
- Latency:
  - Accept at T0 → mem_req_valid from T1.
  - mem_req_ready at T1 → WAIT at T2.
  - mem_rsp_valid at T2 → rsp_valid at T3.
  - Minimum 4 cycles from one accept to the next.
  - All req_ready=0 outside IDLE.
- A requester must hold valid and its fields until ready.
  - Deasserting valid before ready is legal; no grant results.
- busy = (state != IDLE).

Test Plan:
- Reset mid-WAIT: assert rst=0 while in WAIT, then release, then drive mem_rsp_valid=1 → state=IDLE, no rsp_valid pulse, busy=0, mem_req_valid=0.
- Single IFU fetch: ifu_addr=0x80000000, memory ready at once, response rdata=0x00100073 after 1 cycle → ifu_rsp_valid pulses at T3 with ifu_rdata=0x00100073; lsu_rsp_valid stays 0.
- LSU store: addr=0x80001000, wdata=0xDEADBEEF, wmask=4'b0011 → mem_wen=1 and fields held stable for 3 cycles while mem_req_ready=0; lsu_rsp_valid pulse with lsu_rdata=0.
- Simultaneous requests, RR_EN=1, after reset:
  - Expected grant order over 4 back-to-back transactions with both valids held: LSU, IFU, LSU, IFU.
  - With RR_EN=0, the same stimulus gives LSU on all four.
- Slow memory: mem_rsp_valid arrives 5 cycles after accept, with a stray mem_rsp_valid injected during REQ → stray pulse ignored; exactly one response per request; busy=1 throughout.
- Requester drops valid: IFU drops ifu_req_valid in the cycle a grant would occur → IFU is granted only when its valid is high in IDLE; with no valid, no grant and state stays IDLE.
